// File: rtl/multi_decoder.sv
// multi_decoder: recovers RM from CODE = perm(RM,K) ^ perm(RT,K), one word in flight.
//   perm(x,K): rotate left by 2^i for each set K[i] (i=0..4), then bit-reverse if K[5].
//   Sequence: FWD (5 cycles) rebuilds perm(RT,K), MIX (1 cycle) strips it from CODE and
//   applies the reverse, INV (5 cycles) undoes the rotations, DONE holds the result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake for code_in, key_in, rt_in
//   out_valid/ready output handshake for rm_out
//   busy            high whenever the FSM is not IDLE
//   dec_count       completed output handshakes, wraps at 16 bits
module multi_decoder #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] code_in,
  input  logic [BITS-1:0] key_in,
  input  logic [BITS-1:0] rt_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] rm_out,
  output logic            busy,
  output logic [15:0]     dec_count
);

  localparam int unsigned STEP_W    = 3;
  localparam int unsigned KEY_W     = 6;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LAST_STEP = 4;
  localparam int unsigned SHAMT_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_MIX  = 3'd2,
    S_INV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     acc_q, acc_d;
  logic [BITS-1:0]     code_q, code_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [BITS-1:0]     rm_out_q, rm_out_d;
  logic                busy_q, busy_d;
  logic [BITS-1:0]     mix_t, mix_x;

  // Only K[5:0] matter; the rest of the key is intentionally dropped.
  logic unused_key;
  assign unused_key = ^key_in[BITS-1:KEY_W];

  function automatic logic [BITS-1:0] rol_pow2(input logic [BITS-1:0] x,
                                                input logic [STEP_W-1:0] s);
    logic [2*BITS-1:0] d;
    d = {x, x} << (SHAMT_W'(1) << s);
    return d[2*BITS-1:BITS];
  endfunction

  function automatic logic [BITS-1:0] ror_pow2(input logic [BITS-1:0] x,
                                                input logic [STEP_W-1:0] s);
    logic [2*BITS-1:0] d;
    d = {x, x} >> (SHAMT_W'(1) << s);
    return d[BITS-1:0];
  endfunction

  function automatic logic [BITS-1:0] bitrev(input logic [BITS-1:0] x);
    logic [BITS-1:0] r;
    for (int i = 0; i < int'(BITS); i++) r[i] = x[int'(BITS) - 1 - i];
    return r;
  endfunction

  // Ready drops immediately under reset and is high the first cycle after release.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign rm_out    = rm_out_q;
  assign busy      = busy_q;
  assign dec_count = cnt_q;

  // MIX: t = perm(RT,K); XOR it out of CODE, then do the leading reverse of inv().
  assign mix_t = key_q[KEY_W-1] ? bitrev(acc_q) : acc_q;
  assign mix_x = code_q ^ mix_t;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    code_d  = code_q;
    key_d   = key_q;
    step_d  = step_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          code_d  = code_in;
          key_d   = key_in[KEY_W-1:0];
          acc_d   = rt_in;
          step_d  = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        if (key_q[step_q]) acc_d = rol_pow2(acc_q, step_q);
        if (step_q == STEP_W'(LAST_STEP)) begin
          step_d  = '0;
          state_d = S_MIX;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_MIX: begin
        acc_d   = key_q[KEY_W-1] ? bitrev(mix_x) : mix_x;
        state_d = S_INV;
      end
      S_INV: begin
        if (key_q[step_q]) acc_d = ror_pow2(acc_q, step_q);
        if (step_q == STEP_W'(LAST_STEP)) begin
          step_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
    rm_out_d    = out_valid_d ? acc_d : '0;
    busy_d      = (state_d != S_IDLE);
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      code_q      <= '0;
      key_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      rm_out_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      code_q      <= code_d;
      key_q       <= key_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      rm_out_q    <= rm_out_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_multi_decoder.sv
// tb_multi_decoder: directed and random decode checks against a bit-position reference model.
module tb_multi_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] code_in, key_in, rt_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rm_out;
  logic        busy;
  logic [15:0] dec_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;

  multi_decoder #(.BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_in   (code_in),
    .key_in    (key_in),
    .rt_in     (rt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rm_out    (rm_out),
    .busy      (busy),
    .dec_count (dec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: rotations compose to one left rotation by K[4:0]; bit j lands at (j+r) mod 32.
  function automatic logic [31:0] perm_ref(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] y;
    logic [31:0] z;
    int r;
    r = int'(k[4:0]);
    for (int j = 0; j < 32; j++) y[(j + r) % 32] = x[j];
    if (k[5]) begin
      for (int j = 0; j < 32; j++) z[31 - j] = y[j];
      y = z;
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c, input logic [31:0] k, input logic [31:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    code_in  = c;
    key_in   = k;
    rt_in    = r;
    tick();
    in_valid = 1'b0;
    code_in  = $urandom;
    key_in   = $urandom;
    rt_in    = $urandom;
  endtask

  task automatic run_word(input logic [31:0] c, input logic [31:0] k, input logic [31:0] r,
                          input logic [31:0] exp_rm, input int hold, input bit toggle);
    int lat;
    send(c, k, r);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("rm_zero_busy", rm_out, 32'd0);
      if (toggle) in_valid = 1'($urandom);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd11);
    chk("rm_out", rm_out, exp_rm);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      code_in  = $urandom;
      rt_in    = $urandom;
      tick();
      chk("hold_rm", rm_out, exp_rm);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_count", {16'h0, dec_count}, {16'h0, exp_cnt});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_rm_zero", rm_out, 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("dec_count", {16'h0, dec_count}, {16'h0, exp_cnt});
  endtask

  task automatic run_random(input int n);
    logic [31:0] rm, rt, k;
    for (int i = 0; i < n; i++) begin
      rm = $urandom;
      rt = $urandom;
      k  = $urandom;
      run_word(perm_ref(rm, k) ^ perm_ref(rt, k), k, rt, rm, $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    logic [31:0] rm, rt, k;
    bit          seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    code_in   = '0;
    key_in    = '0;
    rt_in     = '0;
    exp_cnt   = 16'd0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rm_out", rm_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", {16'h0, dec_count}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors.
    run_word(32'hFFFF0000, 32'h00000000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 1'b0);
    run_word(32'h00000002, 32'h00000001, 32'h00000000, 32'h00000001, 1, 1'b0);
    run_word(32'h80000000, 32'h00000020, 32'h00000000, 32'h00000001, 2, 1'b1);

    // Stall 20 cycles in DONE with in_valid toggling.
    rm = 32'hDEADBEEF; rt = 32'h12345678; k = 32'hFFFFFFFF;
    run_word(perm_ref(rm, k) ^ perm_ref(rt, k), k, rt, rm, 20, 1'b1);

    // Abort at FWD step 2.
    rm = $urandom; rt = $urandom; k = 32'h0000003F;
    send(perm_ref(rm, k) ^ perm_ref(rt, k), k, rt);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", {16'h0, dec_count}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    rm = $urandom; rt = $urandom; k = $urandom;
    run_word(perm_ref(rm, k) ^ perm_ref(rt, k), k, rt, rm, 1, 1'b0);

    // Reset while waiting in DONE, colliding with out_ready.
    send(32'hFFFF0000, 32'h0, 32'h0F0F0F0F);
    for (int i = 0; i < 11; i++) tick();
    chk("done_before_abort", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = 16'd0;
    chk("done_abort_count", {16'h0, dec_count}, 32'd0);
    chk("done_abort_valid", 32'(out_valid), 32'd0);

    run_random(1000);

    // Wrap of the completion counter from 0xFFFF.
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    run_word(32'hFFFF0000, 32'h00000000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 1'b0);
    chk("wrap_zero", {16'h0, dec_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
